dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter placed in front of the single-port DataMem shared by core 0 and core 1 of the dual-core datapath.
- Grants one access (read or write) per cycle to the memory port and routes the registered memory output back to the issuing core, one cycle later.
- Each core uses a req/gnt command handshake and a rvalid response strobe.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-core round-robin arbiter in front of the single-port DataMem; responses return one cycle after grant.
// Optional ownership locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c0_lock,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic              c1_lock,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              mem_wd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              rr;
    logic              sel_q;
    logic              sel;
    logic              elig0;
    logic              elig1;
    logic              win;
    logic              gnt_any;
    logic              tag_vld_p1;
    logic              tag_id_p1;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef DMEM_ARB_LOCK_EN
    logic owner_vld;
    logic owner_id;
    logic owner_req;
    logic owner_hold;
    logic win_lock;

    // An owner that has dropped req no longer blocks the other core in that same cycle.
    assign owner_req  = owner_id ? c1_req : c0_req;
    assign owner_hold = owner_vld && owner_req;
    assign elig0      = c0_req && !(owner_hold && owner_id);
    assign elig1      = c1_req && !(owner_hold && !owner_id);
    assign win_lock   = win ? c1_lock : c0_lock;
`else
    logic unused_lock;

    assign unused_lock = c0_lock ^ c1_lock;
    assign elig0       = c0_req;
    assign elig1       = c1_req;
`endif

    // Stage p0: combinational grant and memory command
    always_comb begin
        win     = (elig0 && elig1) ? rr : elig1;
        gnt_any = rst_n && (elig0 || elig1);
        sel     = gnt_any ? win : sel_q;
    end

    assign c0_gnt   = gnt_any && !win;
    assign c1_gnt   = gnt_any && win;
    assign mem_wd   = gnt_any && (win ? c1_we : c0_we);
    assign mem_addr = sel ? c1_addr : c0_addr;
    assign mem_din  = sel ? c1_wdata : c0_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr         <= 1'b0;
            sel_q      <= 1'b0;
            tag_vld_p1 <= 1'b0;
            tag_id_p1  <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            owner_vld  <= 1'b0;
            owner_id   <= 1'b0;
`endif
        end else begin
            sel_q      <= sel;
            tag_vld_p1 <= gnt_any;
            tag_id_p1  <= win;
`ifdef DMEM_ARB_LOCK_EN
            if (gnt_any) begin
                if (win_lock) begin
                    owner_vld <= 1'b1;
                    owner_id  <= win;
                end else begin
                    owner_vld <= 1'b0;
                    rr        <= ~win;
                end
            end else if (owner_vld && !owner_req) begin
                owner_vld <= 1'b0;
                rr        <= ~owner_id;
            end
`else
            if (gnt_any) begin
                rr <= ~win;
            end
`endif
        end
    end

    // Stage p1: response routed to the core that owned the previous grant
    assign c0_rvalid = rst_n && tag_vld_p1 && !tag_id_p1;
    assign c1_rvalid = rst_n && tag_vld_p1 && tag_id_p1;
    assign c0_rdata  = c0_rvalid ? mem_dout : rdata0_q;
    assign c1_rdata  = c1_rvalid ? mem_dout : rdata1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (c0_rvalid) begin
                rdata0_q <= mem_dout;
            end
            if (c1_rvalid) begin
                rdata1_q <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed plan steps plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        c0_req, c0_we, c0_lock, c0_gnt, c0_rvalid;
    logic [7:0]  c0_addr;
    logic [63:0] c0_wdata, c0_rdata;
    logic        c1_req, c1_we, c1_lock, c1_gnt, c1_rvalid;
    logic [7:0]  c1_addr;
    logic [63:0] c1_wdata, c1_rdata;
    logic        mem_wd;
    logic [7:0]  mem_addr;
    logic [63:0] mem_din, mem_dout;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [63:0] pre_data;
    logic [63:0] sram [256];

    int tests = 0;
    int failed = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_lock(c0_lock), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_lock(c1_lock), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .mem_wd(mem_wd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered output; a write echoes its data.
    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else begin
            if (mem_wd) sram[mem_addr] <= mem_din;
            mem_dout <= mem_wd ? mem_din : sram[mem_addr];
        end
    end

    // Requester state per core and the reference model
    logic        rq [2];
    logic        wq [2];
    logic        lk [2];
    logic [7:0]  aq [2];
    logic [63:0] dq [2];
    logic [63:0] ref_mem [256];
    logic [63:0] last_rd [2];
    logic [63:0] pend_data;
    int          pend;
    int          pref;
    int          owner;
    int          last_w;
    int          obs_gnt [2];
    logic        last_g1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int k, input logic r, input logic we, input logic [7:0] a,
                            input logic [63:0] d, input logic l);
        rq[k] = r; wq[k] = we; aq[k] = a; dq[k] = d; lk[k] = l;
    endtask

    task automatic cycle();
        logic r0, r1, ev0, ev1;
        int w;
        c0_req = rq[0]; c0_we = wq[0]; c0_addr = aq[0]; c0_wdata = dq[0]; c0_lock = lk[0];
        c1_req = rq[1]; c1_we = wq[1]; c1_addr = aq[1]; c1_wdata = dq[1]; c1_lock = lk[1];
        @(negedge clk);
        r0 = rq[0];
        r1 = rq[1];
`ifdef DMEM_ARB_LOCK_EN
        if (owner == 0 && rq[0]) r1 = 1'b0;
        if (owner == 1 && rq[1]) r0 = 1'b0;
`endif
        w = -1;
        if (r0 && r1) w = pref;
        else if (r0) w = 0;
        else if (r1) w = 1;
        if (!rst_n) w = -1;
        chk("c0_gnt", c0_gnt, w == 0);
        chk("c1_gnt", c1_gnt, w == 1);
        ev0 = rst_n && pend == 0;
        ev1 = rst_n && pend == 1;
        chk("c0_rvalid", c0_rvalid, ev0);
        chk("c1_rvalid", c1_rvalid, ev1);
        if (rst_n) begin
            chk("c0_rdata", c0_rdata, ev0 ? pend_data : last_rd[0]);
            chk("c1_rdata", c1_rdata, ev1 ? pend_data : last_rd[1]);
        end
        if (w >= 0) begin
            chk("mem_wd", mem_wd, wq[w]);
            chk("mem_addr", mem_addr, aq[w]);
            if (wq[w]) chk("mem_din", mem_din, dq[w]);
        end else begin
            chk("mem_wd_idle", mem_wd, 1'b0);
        end
        obs_gnt[0] += int'(c0_gnt);
        obs_gnt[1] += int'(c1_gnt);
        last_g1 = c1_gnt;
        if (!rst_n) begin
            pend = -1; pref = 0; owner = -1;
            last_rd[0] = '0; last_rd[1] = '0;
        end else begin
            if (ev0) last_rd[0] = pend_data;
            if (ev1) last_rd[1] = pend_data;
            pend = -1;
            if (w >= 0) begin
                if (wq[w]) begin
                    ref_mem[aq[w]] = dq[w];
                    pend_data = dq[w];
                end else begin
                    pend_data = ref_mem[aq[w]];
                end
                pend = w;
            end
`ifdef DMEM_ARB_LOCK_EN
            if (w >= 0) begin
                if (lk[w]) owner = w;
                else begin owner = -1; pref = 1 - w; end
            end else if (owner >= 0 && !rq[owner]) begin
                pref = 1 - owner;
                owner = -1;
            end
`else
            if (w >= 0) pref = 1 - w;
`endif
        end
        last_w = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        pend = -1; pref = 0; owner = -1; last_w = -1; pend_data = '0;
        obs_gnt[0] = 0; obs_gnt[1] = 0; last_g1 = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        for (int k = 0; k < 2; k++) set_core(k, 1'b0, 1'b0, 8'h0, 64'h0, 1'b0);
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0; c0_lock = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0; c1_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            pre_we = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i == 1) ? 64'hA : (i == 2) ? 64'hB : {32'hC0DE0000 + 32'(i), $urandom};
            ref_mem[i] = pre_data;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        // Reset state
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Write then read-back of 0x10 by core 0
        set_core(0, 1, 1, 8'h10, 64'hDEADBEEF_00000001, 0);
        cycle();
        set_core(0, 1, 0, 8'h10, 64'h0, 0);
        cycle();
        set_core(0, 0, 0, 8'h10, 64'h0, 0);
        cycle();
        chk("rd_after_wr", c0_rdata, 64'hDEADBEEF_00000001);
        chk("c1_rdata_untouched", c1_rdata, 64'h0);

        // Continuous dual reads alternate
        obs_gnt[0] = 0; obs_gnt[1] = 0;
        set_core(0, 1, 0, 8'h01, 64'h0, 0);
        set_core(1, 1, 0, 8'h02, 64'h0, 0);
        repeat (6) cycle();
        set_core(0, 0, 0, 8'h01, 64'h0, 0);
        set_core(1, 0, 0, 8'h02, 64'h0, 0);
        cycle();
        chk("alt_c0_grants", 64'(obs_gnt[0]), 64'd3);
        chk("alt_c1_grants", 64'(obs_gnt[1]), 64'd3);
        chk("alt_c0_data", c0_rdata, 64'hA);
        chk("alt_c1_data", c1_rdata, 64'hB);

        // rr=1: core 1 write to 0x20 wins, core 0 read of 0x20 follows
        set_core(0, 1, 0, 8'h05, 64'h0, 0);
        cycle();
        set_core(0, 1, 0, 8'h20, 64'h0, 0);
        set_core(1, 1, 1, 8'h20, 64'h5, 0);
        cycle();
        chk("wr_first_c1", 64'(last_g1), 64'd1);
        set_core(1, 0, 0, 8'h20, 64'h0, 0);
        cycle();
        set_core(0, 0, 0, 8'h20, 64'h0, 0);
        cycle();
        chk("rd_new_data", c0_rdata, 64'h5);

        // Reset taken the cycle after a grant drops the response
        set_core(0, 1, 0, 8'h03, 64'h0, 0);
        cycle();
        set_core(0, 0, 0, 8'h03, 64'h0, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_core(0, 1, 0, 8'h04, 64'h0, 0);
        set_core(1, 1, 0, 8'h05, 64'h0, 0);
        cycle();
        chk("post_reset_c1_waits", 64'(last_g1), 64'd0);
        set_core(0, 0, 0, 8'h04, 64'h0, 0);
        cycle();
        set_core(1, 0, 0, 8'h05, 64'h0, 0);
        cycle();

        // Core 0 accesses with lock 1,1,0 while core 1 keeps requesting
        set_core(1, 1, 0, 8'h09, 64'h0, 0);
        set_core(0, 1, 0, 8'h06, 64'h0, 1);
        cycle();
        set_core(0, 1, 1, 8'h07, 64'h77, 1);
        cycle();
`ifdef DMEM_ARB_LOCK_EN
        chk("lock_c1_blocked2", 64'(last_g1), 64'd0);
`endif
        set_core(0, 1, 0, 8'h07, 64'h0, 0);
        cycle();
`ifdef DMEM_ARB_LOCK_EN
        chk("lock_c1_blocked3", 64'(last_g1), 64'd0);
`endif
        set_core(0, 0, 0, 8'h07, 64'h0, 0);
        cycle();
        set_core(1, 0, 0, 8'h09, 64'h0, 0);
        cycle();

        // Random traffic; a pending request is held (or occasionally dropped) until granted
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (rq[k] && last_w != k) begin
                    if ($urandom_range(0, 7) == 0) rq[k] = 1'b0;
                end else begin
                    set_core(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                             8'($urandom_range(0, 15)), {$urandom, $urandom},
                             $urandom_range(0, 3) == 0);
                end
            end
            cycle();
        end
        for (int k = 0; k < 2; k++) set_core(k, 0, 0, 8'h0, 64'h0, 0);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
